fetch_issue_ctrl: RTL

//   Fetch/issue controller directly upstream of the 16-bit program counter.

---
 rtl/fetch_issue_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/fetch_issue_ctrl.sv
// fetch_issue_ctrl: fetch/issue controller sitting directly upstream of the PC.
//   It fetches the word at pc over a req/ack handshake and holds it in ir.
//   It then offers ir downstream over a valid/ready handshake.
//   In the cycle ir is accepted it drives exactly one PC command: inc, add or sub.
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   pc                      current PC value from the PC block
//   imem_addr/req/rdata/ack instruction memory fetch handshake
//   ir, ir_pc, ir_valid     held instruction, its fetch address, valid flag
//   ir_ready                downstream accepts ir this cycle
//   zero                    condition flag used by the branch-if-zero opcode
//   inc/add/sub/offset      PC command, combinational, asserted only in the accept cycle
module fetch_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        zero,
    output logic        inc,
    output logic        add,
    output logic        sub,
    output logic [15:0] offset
);

    localparam int unsigned W = 16;

    localparam logic [3:0] OPC_BRF = 4'hC;
    localparam logic [3:0] OPC_BRB = 4'hD;
    localparam logic [3:0] OPC_BZ  = 4'hE;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [W-1:0] ir_q, ir_d;
    logic [W-1:0] ir_pc_q, ir_pc_d;

    logic [3:0]   opcode;
    logic [W-1:0] imm;

    assign opcode = ir_q[15:12];
    assign imm    = {4'b0000, ir_q[11:0]};

    // State and instruction registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            ir_pc_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
        end
    end

    // Next state, ir capture and the one-cycle PC command
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        inc     = 1'b0;
        add     = 1'b0;
        sub     = 1'b0;
        offset  = '0;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    ir_pc_d = pc;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // imem_ack is ignored here so a stray ack cannot clobber ir
                if (ir_ready) begin
                    state_d = ST_FETCH;
                    case (opcode)
                        OPC_BRF: begin
                            add    = 1'b1;
                            offset = imm;
                        end
                        OPC_BRB: begin
                            sub    = 1'b1;
                            offset = imm;
                        end
                        OPC_BZ: begin
                            if (zero) begin
                                add    = 1'b1;
                                offset = imm;
                            end else begin
                                inc = 1'b1;
                            end
                        end
                        default: inc = 1'b1;
                    endcase
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign imem_addr = pc;
    assign imem_req  = (state_q == ST_FETCH);
    assign ir_valid  = (state_q == ST_ISSUE);
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;

endmodule
